bnn_layer_engine: RTL and testbench



---
 rtl/bnn_pkg.sv | 34 +++
 rtl/bnn_layer_engine_if.sv | 29 ++
 rtl/bnn_popcount.sv | 20 ++
 rtl/bnn_layer_engine.sv | 277 +++++++++++++++++++++++++++
 tb/tb_bnn_layer_engine.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binarised fully-connected layer engine.
// Contents: FSM state enum, default lane count, clog2 helper and the
// accumulator-width sanity function used at elaboration.
package bnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_ACT,
    ST_WR,
    ST_DONE
  } state_e;

  localparam int unsigned LANES_DEF = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // The largest possible popcount sum must fit in the accumulator.
  function automatic bit acc_w_ok(input int unsigned cnt_len,
                                  input int unsigned lanes,
                                  input int unsigned acc_w);
    return (((64'd1 << cnt_len) - 64'd1) * 64'(lanes)) < (64'd1 << acc_w);
  endfunction

endpackage

// File: rtl/bnn_layer_engine_if.sv
// Memory-side bus of the layer engine: weight read port, activation read
// port and activation write port.
// master: engine (drives strobes/addresses/write data, receives read data)
// slave : memories (return read data one cycle after the strobe)
interface bnn_layer_engine_if #(
  parameter int unsigned LANES      = 8,
  parameter int unsigned W_ADDR_LEN = 20,
  parameter int unsigned X_ADDR_LEN = 10
);
  logic                  w_rd_en;
  logic [W_ADDR_LEN-1:0] w_addr;
  logic [LANES-1:0]      w_rdata;
  logic                  x_rd_en;
  logic [X_ADDR_LEN-1:0] x_rd_addr;
  logic [LANES-1:0]      x_rdata;
  logic                  x_wr_en;
  logic [X_ADDR_LEN-1:0] x_wr_addr;
  logic [LANES-1:0]      x_wr_data;

  modport master (
    output w_rd_en, w_addr, x_rd_en, x_rd_addr, x_wr_en, x_wr_addr, x_wr_data,
    input  w_rdata, x_rdata
  );

  modport slave (
    input  w_rd_en, w_addr, x_rd_en, x_rd_addr, x_wr_en, x_wr_addr, x_wr_data,
    output w_rdata, x_rdata
  );
endinterface

// File: rtl/bnn_popcount.sv
// Combinational population count of a LANES-bit vector.
// Ports: bits_i (LANES) in, count_c (clog2(LANES+1)) out.
module bnn_popcount
  import bnn_pkg::*;
#(
  parameter  int unsigned LANES = LANES_DEF,
  localparam int unsigned CNT_W = clog2(LANES + 1)
) (
  input  logic [LANES-1:0] bits_i,
  output logic [CNT_W-1:0] count_c
);

  always_comb begin
    count_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      count_c = count_c + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/bnn_layer_engine.sv
// One binarised fully-connected layer per start: streams weight/activation
// words, accumulates XNOR-popcount per neuron, applies sign activation
// (or a latched threshold when BNN_THRESH_EN is defined) and packs the
// result bits into activation-memory words.
// Ports: clk, rst (sync, active-high); start + latched config
// (n_in_words, n_out, w_base, x_in_base, x_out_base[, thresh]);
// busy/done status; mem = memory bus (master side).
// Optional macro: BNN_THRESH_EN adds the thresh input port.
module bnn_layer_engine
  import bnn_pkg::*;
#(
  parameter int unsigned LANES      = LANES_DEF,
  parameter int unsigned W_ADDR_LEN = 20,
  parameter int unsigned X_ADDR_LEN = 10,
  parameter int unsigned CNT_LEN    = 11,
  parameter int unsigned ACC_W      = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_LEN-1:0]    n_in_words,
  input  logic [CNT_LEN-1:0]    n_out,
  input  logic [W_ADDR_LEN-1:0] w_base,
  input  logic [X_ADDR_LEN-1:0] x_in_base,
  input  logic [X_ADDR_LEN-1:0] x_out_base,
`ifdef BNN_THRESH_EN
  input  logic [ACC_W-1:0]      thresh,
`endif
  output logic                  busy,
  output logic                  done,
  bnn_layer_engine_if.master    mem
);

  localparam int unsigned POP_W  = clog2(LANES + 1);
  localparam int unsigned LANE_W = (clog2(LANES) > 0) ? clog2(LANES) : 1;

  if (!acc_w_ok(CNT_LEN, LANES, ACC_W)) begin : g_acc_w_check
    $error("ACC_W too narrow for CNT_LEN and LANES");
  end

  state_e                state_q, state_d;
  logic [CNT_LEN-1:0]    n_in_q, n_in_d;
  logic [CNT_LEN-1:0]    n_out_q, n_out_d;
  logic [X_ADDR_LEN-1:0] x_in_base_q, x_in_base_d;
  logic [X_ADDR_LEN-1:0] x_out_base_q, x_out_base_d;
  logic [W_ADDR_LEN-1:0] w_ptr_q, w_ptr_d;
  logic [CNT_LEN-1:0]    neuron_q, neuron_d;
  logic [CNT_LEN-1:0]    word_q, word_d;
  logic [CNT_LEN-1:0]    out_word_q, out_word_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [LANES-1:0]      pack_q, pack_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  w_rd_en_q, w_rd_en_d;
  logic [W_ADDR_LEN-1:0] w_addr_q, w_addr_d;
  logic                  x_rd_en_q, x_rd_en_d;
  logic [X_ADDR_LEN-1:0] x_rd_addr_q, x_rd_addr_d;
  logic                  x_wr_en_q, x_wr_en_d;
  logic [X_ADDR_LEN-1:0] x_wr_addr_q, x_wr_addr_d;
  logic [LANES-1:0]      x_wr_data_q, x_wr_data_d;
`ifdef BNN_THRESH_EN
  logic [ACC_W-1:0]      thresh_q, thresh_d;
`endif

  logic [POP_W-1:0]      pop_c;
  logic                  act_bit_c;
  logic                  last_neuron_c;
  logic                  fetch_start_c;
  logic [LANES-1:0]      pack_set_c;

  bnn_popcount #(.LANES(LANES)) u_popcount (
    .bits_i  (~(mem.w_rdata ^ mem.x_rdata)),
    .count_c (pop_c)
  );

  // Activation decision on the finished accumulator.
`ifdef BNN_THRESH_EN
  assign act_bit_c = (acc_q >= thresh_q);
`else
  // 2*acc >= n_in*LANES in ACC_W+1 bits; ties resolve to 1.
  assign act_bit_c = ({acc_q, 1'b0} >=
                      ((ACC_W + 1)'(n_in_q) * (ACC_W + 1)'(LANES)));
`endif

  assign last_neuron_c = (neuron_q == (n_out_q - CNT_LEN'(1)));

  always_comb begin
    pack_set_c         = pack_q;
    pack_set_c[lane_q] = act_bit_c;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    n_in_d        = n_in_q;
    n_out_d       = n_out_q;
    x_in_base_d   = x_in_base_q;
    x_out_base_d  = x_out_base_q;
    w_ptr_d       = w_ptr_q;
    neuron_d      = neuron_q;
    word_d        = word_q;
    out_word_d    = out_word_q;
    lane_d        = lane_q;
    pack_d        = pack_q;
    w_addr_d      = w_addr_q;
    x_rd_addr_d   = x_rd_addr_q;
    x_wr_addr_d   = x_wr_addr_q;
    x_wr_data_d   = x_wr_data_q;
`ifdef BNN_THRESH_EN
    thresh_d      = thresh_q;
`endif
    w_rd_en_d     = 1'b0;
    x_rd_en_d     = 1'b0;
    x_wr_en_d     = 1'b0;
    fetch_start_c = 1'b0;
    // Data returns one cycle after each strobe.
    rd_valid_d    = w_rd_en_q;
    acc_d         = rd_valid_q ? (acc_q + ACC_W'(pop_c)) : acc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_in_d       = n_in_words;
          n_out_d      = n_out;
          x_in_base_d  = x_in_base;
          x_out_base_d = x_out_base;
          w_ptr_d      = w_base;
`ifdef BNN_THRESH_EN
          thresh_d     = thresh;
`endif
          if ((n_in_words == '0) || (n_out == '0)) begin
            state_d = ST_DONE;
          end else begin
            neuron_d      = '0;
            out_word_d    = '0;
            lane_d        = '0;
            pack_d        = '0;
            acc_d         = '0;
            fetch_start_c = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        // word_q counts reads already issued for this neuron.
        if (word_q == n_in_q) begin
          state_d = ST_DRAIN;
        end else begin
          w_rd_en_d   = 1'b1;
          x_rd_en_d   = 1'b1;
          w_addr_d    = w_ptr_q;
          w_ptr_d     = w_ptr_q + W_ADDR_LEN'(1);
          x_rd_addr_d = x_in_base_q + X_ADDR_LEN'(word_q);
          word_d      = word_q + CNT_LEN'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_ACT;
      end
      ST_ACT: begin
        acc_d  = '0;
        pack_d = pack_set_c;
        if ((lane_q == LANE_W'(LANES - 1)) || last_neuron_c) begin
          state_d     = ST_WR;
          x_wr_en_d   = 1'b1;
          x_wr_addr_d = x_out_base_q + X_ADDR_LEN'(out_word_q);
          x_wr_data_d = pack_set_c;
        end else begin
          lane_d        = lane_q + LANE_W'(1);
          neuron_d      = neuron_q + CNT_LEN'(1);
          fetch_start_c = 1'b1;
        end
      end
      ST_WR: begin
        pack_d     = '0;
        lane_d     = '0;
        out_word_d = out_word_q + CNT_LEN'(1);
        if (last_neuron_c) begin
          state_d = ST_DONE;
        end else begin
          neuron_d      = neuron_q + CNT_LEN'(1);
          fetch_start_c = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // First read of a neuron issues in the same cycle FETCH is entered.
    if (fetch_start_c) begin
      state_d     = ST_FETCH;
      w_rd_en_d   = 1'b1;
      x_rd_en_d   = 1'b1;
      w_addr_d    = w_ptr_d;
      w_ptr_d     = w_ptr_d + W_ADDR_LEN'(1);
      x_rd_addr_d = x_in_base_d;
      word_d      = CNT_LEN'(1);
    end

    busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN) ||
             (state_d == ST_ACT)   || (state_d == ST_WR);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      n_in_q       <= '0;
      n_out_q      <= '0;
      x_in_base_q  <= '0;
      x_out_base_q <= '0;
      w_ptr_q      <= '0;
      neuron_q     <= '0;
      word_q       <= '0;
      out_word_q   <= '0;
      lane_q       <= '0;
      acc_q        <= '0;
      pack_q       <= '0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      w_rd_en_q    <= 1'b0;
      w_addr_q     <= '0;
      x_rd_en_q    <= 1'b0;
      x_rd_addr_q  <= '0;
      x_wr_en_q    <= 1'b0;
      x_wr_addr_q  <= '0;
      x_wr_data_q  <= '0;
`ifdef BNN_THRESH_EN
      thresh_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      n_in_q       <= n_in_d;
      n_out_q      <= n_out_d;
      x_in_base_q  <= x_in_base_d;
      x_out_base_q <= x_out_base_d;
      w_ptr_q      <= w_ptr_d;
      neuron_q     <= neuron_d;
      word_q       <= word_d;
      out_word_q   <= out_word_d;
      lane_q       <= lane_d;
      acc_q        <= acc_d;
      pack_q       <= pack_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      w_rd_en_q    <= w_rd_en_d;
      w_addr_q     <= w_addr_d;
      x_rd_en_q    <= x_rd_en_d;
      x_rd_addr_q  <= x_rd_addr_d;
      x_wr_en_q    <= x_wr_en_d;
      x_wr_addr_q  <= x_wr_addr_d;
      x_wr_data_q  <= x_wr_data_d;
`ifdef BNN_THRESH_EN
      thresh_q     <= thresh_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mem.w_rd_en   = w_rd_en_q;
  assign mem.w_addr    = w_addr_q;
  assign mem.x_rd_en   = x_rd_en_q;
  assign mem.x_rd_addr = x_rd_addr_q;
  assign mem.x_wr_en   = x_wr_en_q;
  assign mem.x_wr_addr = x_wr_addr_q;
  assign mem.x_wr_data = x_wr_data_q;

endmodule

// File: tb/tb_bnn_layer_engine.sv
// Self-checking bench for bnn_layer_engine: directed layers, a reference
// model that pushes expected writes into a scoreboard queue, and cycle-exact
// checks of done timing, read-address sequence and strobe exclusivity.
module tb_bnn_layer_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] n_in_words;
  logic [10:0] n_out;
  logic [19:0] w_base;
  logic [9:0]  x_in_base;
  logic [9:0]  x_out_base;
  logic        busy;
  logic        done;
`ifdef BNN_THRESH_EN
  logic [13:0] thresh;
`endif

  always #5 clk = ~clk;

  bnn_layer_engine_if #(.LANES(8), .W_ADDR_LEN(20), .X_ADDR_LEN(10)) mem ();

  bnn_layer_engine #(
    .LANES(8), .W_ADDR_LEN(20), .X_ADDR_LEN(10), .CNT_LEN(11), .ACC_W(14)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_in_words (n_in_words),
    .n_out      (n_out),
    .w_base     (w_base),
    .x_in_base  (x_in_base),
    .x_out_base (x_out_base),
`ifdef BNN_THRESH_EN
    .thresh     (thresh),
`endif
    .busy       (busy),
    .done       (done),
    .mem        (mem)
  );

  // Bench memories: weights aliased on the low 8 address bits.
  logic [7:0] wmem [0:255];
  logic [7:0] xmem [0:1023];

  always @(posedge clk) begin
    if (mem.w_rd_en) mem.w_rdata <= wmem[mem.w_addr[7:0]];
    if (mem.x_rd_en) mem.x_rdata <= xmem[mem.x_rd_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [17:0] exp_q [$];   // {x_wr_addr, x_wr_data}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int popc8(input logic [7:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  // Reference layer: pushes every expected write into the scoreboard.
  task automatic push_model(input int ni, input int no, input int wb,
                            input int xib, input int xob, input int th);
    logic [7:0] pack;
    int acc;
    logic b;
    pack = 8'h00;
    for (int j = 0; j < no; j++) begin
      acc = 0;
      for (int i = 0; i < ni; i++)
        acc += popc8(~(wmem[(wb + j*ni + i) & 255] ^ xmem[(xib + i) & 1023]));
`ifdef BNN_THRESH_EN
      b = (acc >= th);
`else
      b = (2*acc >= ni*8) || (th < 0);
`endif
      pack[j % 8] = b;
      if ((j % 8 == 7) || (j == no - 1)) begin
        exp_q.push_back({10'(xob + j/8), pack});
        pack = 8'h00;
      end
    end
  endtask

  task automatic cfg(input int ni, input int no, input int wb, input int xib, input int xob);
    n_in_words = 11'(ni);
    n_out      = 11'(no);
    w_base     = 20'(wb);
    x_in_base  = 10'(xib);
    x_out_base = 10'(xob);
`ifdef BNN_THRESH_EN
    thresh     = 14'(ni * 4);   // equivalent to the sign rule
`endif
  endtask

  // Start a layer and watch it to completion; poke_at>0 pulses a bogus
  // start (with zeroed config) during that cycle.
  task automatic run(input string tag, input int exp_cycles, input int exp_reads, input int poke_at);
    int k, reads, both, done_k;
    logic [19:0] exp_wa;
    logic [17:0] e;
    exp_wa = w_base;
    reads = 0; both = 0; done_k = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 1;
    chk({tag, " busy_after_start"}, 32'(busy), 32'(exp_cycles > 1));
    while (k <= exp_cycles + 20) begin
      if (mem.w_rd_en) begin
        chk({tag, " w_addr_seq"}, 32'(mem.w_addr), 32'(exp_wa));
        exp_wa = exp_wa + 20'd1;
        reads++;
      end
      if ((mem.w_rd_en || mem.x_rd_en) && mem.x_wr_en) both++;
      if (mem.x_wr_en) begin
        chk({tag, " write_expected"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({tag, " write_addr_data"}, 32'({mem.x_wr_addr, mem.x_wr_data}), 32'(e));
        end
      end
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      if (k == poke_at) begin
        start = 1'b1; n_out = '0; n_in_words = '0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, " done_cycle"}, 32'(done_k), 32'(exp_cycles));
    chk({tag, " read_count"}, 32'(reads), 32'(exp_reads));
    chk({tag, " rw_overlap"}, 32'(both), 32'd0);
    chk({tag, " scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int quiet;
    rst = 1'b1; start = 1'b0;
    cfg(0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++)  wmem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) xmem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset strobes", 32'({mem.w_rd_en, mem.x_rd_en, mem.x_wr_en}), 32'd0);
    chk("reset w_addr", 32'(mem.w_addr), 32'd0);
    chk("reset x_wr_data", 32'(mem.x_wr_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: all matching -> acc=8 -> bit 1
    cfg(1, 1, 'h10, 'h20, 'h40);
    wmem['h10] = 8'hFF; xmem['h20] = 8'hFF;
    exp_q.push_back({10'h040, 8'h01});
    run("t1_full", 5, 1, 0);

    // 2: tie acc=4 -> 1; acc=3 -> 0
    wmem['h10] = 8'h0F;
    exp_q.push_back({10'h040, 8'h01});
    run("t2_tie", 5, 1, 0);
    wmem['h10] = 8'h07;
    exp_q.push_back({10'h040, 8'h00});
    run("t2_below", 5, 1, 0);

    // 3: 3 words x 10 neurons, weights equal inputs -> 0xFF, 0x03
    cfg(3, 10, 'h30, 'h100, 'h50);
    for (int i = 0; i < 3; i++) xmem['h100 + i] = 8'(8'h5A + 8'(i * 17));
    for (int j = 0; j < 10; j++)
      for (int i = 0; i < 3; i++) wmem['h30 + j*3 + i] = xmem['h100 + i];
    exp_q.push_back({10'h050, 8'hFF});
    exp_q.push_back({10'h051, 8'h03});
    run("t3_multi", 53, 30, 0);

    // 4: reset in the middle of neuron 5's fetch
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k < 27; k++) @(negedge clk);
    chk("t4 pre_reset_rd_en", 32'(mem.w_rd_en), 32'd1);
    chk("t4 pre_reset_w_addr", 32'(mem.w_addr), 32'h30 + 32'd16);
    rst = 1'b1;
    @(negedge clk);
    chk("t4 post_reset_strobes", 32'({mem.w_rd_en, mem.x_rd_en, mem.x_wr_en}), 32'd0);
    chk("t4 post_reset_busy_done", 32'({busy, done}), 32'd0);
    chk("t4 post_reset_addrs", 32'({mem.x_rd_addr, mem.x_wr_addr}), 32'd0);
    chk("t4 post_reset_w_addr", 32'(mem.w_addr), 32'd0);
    rst = 1'b0;
    quiet = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (mem.w_rd_en || mem.x_rd_en || mem.x_wr_en || busy || done) quiet++;
    end
    chk("t4 idle_after_reset", 32'(quiet), 32'd0);
    for (int j = 0; j < 10; j++)
      for (int i = 0; i < 3; i++) wmem['h30 + j*3 + i] = 8'($urandom_range(0, 255));
    push_model(3, 10, 'h30, 'h100, 'h50, 0);
    run("t4_rerun", 53, 30, 0);

    // 5: empty layers finish with no memory traffic
    cfg(3, 0, 'h30, 'h100, 'h50);
    run("t5_nout0", 1, 0, 0);
    cfg(0, 4, 'h30, 'h100, 'h50);
    run("t5_nin0", 1, 0, 0);

    // random data, start poked while busy (config also changed)
    cfg(2, 11, 'h80, 'h200, 'h300);
    for (int i = 0; i < 22; i++) wmem['h80 + i] = 8'($urandom_range(0, 255));
    xmem['h200] = 8'($urandom_range(0, 255));
    xmem['h201] = 8'($urandom_range(0, 255));
    push_model(2, 11, 'h80, 'h200, 'h300, 0);
    run("t5_busy_start", 47, 22, 10);

    // address wrap on weight pointer and output word address
    cfg(1, 9, 'hFFFFE, 'h3F0, 'h3FF);
    for (int j = 0; j < 9; j++) wmem[(8'hFE + j) & 255] = 8'($urandom_range(0, 255));
    xmem['h3F0] = 8'hC3;
    push_model(1, 9, 'hFFFFE, 'h3F0, 'h3FF, 0);
    run("t7_wrap", 30, 9, 0);

`ifdef BNN_THRESH_EN
    // 6: threshold activation
    cfg(1, 1, 'h10, 'h20, 'h40);
    wmem['h10] = 8'h1F; xmem['h20] = 8'hFF;
    thresh = 14'd5;
    exp_q.push_back({10'h040, 8'h01});
    run("t6_thresh_eq", 5, 1, 0);
    thresh = 14'd6;
    exp_q.push_back({10'h040, 8'h00});
    run("t6_thresh_above", 5, 1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
